// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 serial-side receiver model.
// Holds the register address map, frame length, receiver FSM encoding,
// synchroniser bit lanes and register reset values.
package max7219_pkg;

  localparam int unsigned FRAME_BITS = 16;

  // Register address map (frame bits 11:8)
  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_DISPTEST  = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_READY     = 2'd1,
    ST_SHIFT     = 2'd2
  } rx_state_e;

  // Lane order of the SPI synchroniser vector
  localparam int unsigned LANE_MOSI = 0;
  localparam int unsigned LANE_CLK  = 1;
  localparam int unsigned LANE_CS   = 2;

  // Reset values
  localparam logic [7:0] RST_DIGIT      = 8'h00;
  localparam logic [7:0] RST_DECODE     = 8'h00;
  localparam logic [3:0] RST_INTENSITY  = 4'h0;
  localparam logic [2:0] RST_SCANLIMIT  = 3'h0;
  localparam logic       RST_SHUTDOWN_N = 1'b0;
  localparam logic       RST_DISPTEST   = 1'b0;
  localparam logic       RST_DOUT       = 1'b0;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchroniser plus history flop for the SPI input pins.
// Ports:
//   clk_in - system clock
//   init   - synchronous active-high reset
//   din    - asynchronous pin levels
//   level  - synchronised levels
//   rise   - one-cycle pulse on a synchronised 0->1 transition
//   fall   - one-cycle pulse on a synchronised 1->0 transition
module spi_in_sync #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_in,
  input  logic             init,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] hist;

  always_ff @(posedge clk_in) begin
    if (init) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~hist;
  assign fall  = ~sync2 & hist;

endmodule

// File: rtl/max7219_rx.sv
// Serial-side model of one MAX7219 display driver.
// Oversamples SPI_MOSI/SPI_CLK/SPI_CS, shifts in MSB-first 16-bit frames and
// latches them into the MAX7219 register file on the CS rising edge.
// Shifted-out bits are repeated on DOUT for daisy chains.
// Ports:
//   clk_in, init            - system clock, synchronous active-high reset
//   SPI_MOSI/SPI_CLK/SPI_CS - serial inputs (CS active low)
//   DOUT                    - daisy-chain output, bit received 16 clocks earlier
//   reg_wr_valid            - one-cycle pulse per accepted frame
//   reg_addr/reg_data       - address/data of the last accepted frame
//   short_frame             - one-cycle pulse when CS rises before 16 bits
//   rd_digit/rd_data        - combinational digit register read port
//   decode_mode, intensity, scan_limit, shutdown_n, display_test - control regs
module max7219_rx #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic       clk_in,
  input  logic       init,
  input  logic       SPI_MOSI,
  input  logic       SPI_CLK,
  input  logic       SPI_CS,
  output logic       DOUT,
  output logic       reg_wr_valid,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       short_frame,
  input  logic [2:0] rd_digit,
  output logic [7:0] rd_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown_n,
  output logic       display_test
);

  import max7219_pkg::*;

  logic [2:0] sync_level;
  logic [2:0] sync_rise;
  logic [2:0] sync_fall;

  spi_in_sync #(.WIDTH(3)) u_sync (
    .clk_in (clk_in),
    .init   (init),
    .din    ({SPI_CS, SPI_CLK, SPI_MOSI}),
    .level  (sync_level),
    .rise   (sync_rise),
    .fall   (sync_fall)
  );

  logic mosi_s;
  logic cs_s;
  logic clk_rise;
  logic clk_fall;
  logic cs_fall;
  logic cs_rise;

  assign mosi_s   = sync_level[LANE_MOSI];
  assign cs_s     = sync_level[LANE_CS];
  assign clk_rise = sync_rise[LANE_CLK];
  assign clk_fall = sync_fall[LANE_CLK];
  assign cs_rise  = sync_rise[LANE_CS];
  assign cs_fall  = sync_fall[LANE_CS];

  logic unused_sync;
  assign unused_sync = ^{sync_level[LANE_CLK], sync_rise[LANE_MOSI], sync_fall[LANE_MOSI]};

  rx_state_e             state;
  logic [FRAME_BITS-1:0] sr;
  logic [4:0]            count;
  logic                  load;
  logic                  frame_short;
  logic [3:0]            frame_addr;
  logic [7:0]            frame_data;

  assign frame_addr = sr[11:8];
  assign frame_data = sr[7:0];

  // CS rising ends the frame and takes priority over any SPI clock edge
  // detected in the same cycle.
  always_comb begin
    load        = 1'b0;
    frame_short = 1'b0;
    if (state == ST_SHIFT && cs_rise) begin
      if (count >= 5'(FRAME_BITS)) load = 1'b1;
      else                         frame_short = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (init) begin
      state        <= ST_WAIT_IDLE;
      sr           <= '0;
      count        <= '0;
      DOUT         <= RST_DOUT;
      reg_wr_valid <= 1'b0;
      short_frame  <= 1'b0;
      reg_addr     <= '0;
      reg_data     <= '0;
    end else begin
      reg_wr_valid <= load;
      short_frame  <= frame_short;
      if (load) begin
        reg_addr <= frame_addr;
        reg_data <= frame_data;
      end
      unique case (state)
        // A frame cut by reset is dropped: wait for CS to be seen high.
        ST_WAIT_IDLE: if (cs_s) state <= ST_READY;
        ST_READY: begin
          if (cs_fall) begin
            state <= ST_SHIFT;
            count <= '0;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state <= ST_READY;
          end else if (clk_rise) begin
            sr <= {sr[FRAME_BITS-2:0], mosi_s};
            if (count != 5'd31) count <= count + 5'd1;
          end else if (clk_fall) begin
            DOUT <= sr[FRAME_BITS-1];
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

  logic [7:0] digit [NUM_DIGITS];

  always_ff @(posedge clk_in) begin
    if (init) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit[i] <= RST_DIGIT;
      decode_mode  <= RST_DECODE;
      intensity    <= RST_INTENSITY;
      scan_limit   <= RST_SCANLIMIT;
      shutdown_n   <= RST_SHUTDOWN_N;
      display_test <= RST_DISPTEST;
    end else if (load) begin
      // Digit addresses beyond NUM_DIGITS match no entry and are dropped.
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (frame_addr == ADDR_DIGIT0 + 4'(i)) digit[i] <= frame_data;
      end
      case (frame_addr)
        ADDR_DECODE:    decode_mode  <= frame_data;
        ADDR_INTENSITY: intensity    <= frame_data[3:0];
        ADDR_SCANLIMIT: scan_limit   <= frame_data[2:0];
        ADDR_SHUTDOWN:  shutdown_n   <= frame_data[0];
        ADDR_DISPTEST:  display_test <= frame_data[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (rd_digit == 3'(i)) rd_data = digit[i];
    end
  end

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: two chained instances (u0 fed from the bench, u1 fed
// from u0's DOUT), directed frames plus random frames, checked against a
// frame-level register model and a 16-bit delay-line model of DOUT.
module tb_max7219_rx;

  localparam int H = 4;  // clk_in periods per SPI_CLK phase

  logic clk_in = 1'b0;
  logic init   = 1'b1;
  logic mosi   = 1'b0;
  logic sclk   = 1'b0;
  logic cs     = 1'b1;

  logic       dout  [2];
  logic       wv    [2];
  logic [3:0] raddr [2];
  logic [7:0] rdat  [2];
  logic       sf    [2];
  logic [2:0] rdi   [2];
  logic [7:0] rdd   [2];
  logic [7:0] dec   [2];
  logic [3:0] inten [2];
  logic [2:0] scan  [2];
  logic       shut  [2];
  logic       dtest [2];

  always #5 clk_in = ~clk_in;

  max7219_rx #(.NUM_DIGITS(8), .FRAME_BITS(16)) u0 (
    .clk_in(clk_in), .init(init), .SPI_MOSI(mosi), .SPI_CLK(sclk), .SPI_CS(cs),
    .DOUT(dout[0]), .reg_wr_valid(wv[0]), .reg_addr(raddr[0]), .reg_data(rdat[0]),
    .short_frame(sf[0]), .rd_digit(rdi[0]), .rd_data(rdd[0]), .decode_mode(dec[0]),
    .intensity(inten[0]), .scan_limit(scan[0]), .shutdown_n(shut[0]),
    .display_test(dtest[0])
  );

  max7219_rx #(.NUM_DIGITS(8), .FRAME_BITS(16)) u1 (
    .clk_in(clk_in), .init(init), .SPI_MOSI(dout[0]), .SPI_CLK(sclk), .SPI_CS(cs),
    .DOUT(dout[1]), .reg_wr_valid(wv[1]), .reg_addr(raddr[1]), .reg_data(rdat[1]),
    .short_frame(sf[1]), .rd_digit(rdi[1]), .rd_data(rdd[1]), .decode_mode(dec[1]),
    .intensity(inten[1]), .scan_limit(scan[1]), .shutdown_n(shut[1]),
    .display_test(dtest[1])
  );

  int checks = 0;
  int failures = 0;

  // Pulse counters
  int n_wv [2] = '{0, 0};
  int n_sf [2] = '{0, 0};

  always @(negedge clk_in) begin
    for (int c = 0; c < 2; c++) begin
      if (wv[c] === 1'b1) n_wv[c]++;
      if (sf[c] === 1'b1) n_sf[c]++;
    end
  end

  // Reference model
  int         e_wv   [2] = '{0, 0};
  int         e_sf   [2] = '{0, 0};
  logic [7:0] e_dig  [2][8];
  logic [7:0] e_dec  [2];
  logic [3:0] e_int  [2];
  logic [2:0] e_scan [2];
  logic       e_shut [2];
  logic       e_test [2];
  logic [3:0] e_addr [2];
  logic [7:0] e_data [2];
  bit         dq0 [$];
  bit         dq1 [$];
  logic [31:0] acc [2];
  int          nbits;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 8; d++) e_dig[c][d] = 8'h00;
      e_dec[c] = '0; e_int[c] = '0; e_scan[c] = '0;
      e_shut[c] = 1'b0; e_test[c] = 1'b0;
      e_addr[c] = '0; e_data[c] = '0;
    end
    dq0.delete();
    dq1.delete();
    for (int i = 0; i < 16; i++) begin
      dq0.push_back(1'b0);
      dq1.push_back(1'b0);
    end
  endtask

  task automatic model_load(input int c, input logic [15:0] f);
    int a;
    logic [7:0] d;
    a = int'(f[11:8]);
    d = f[7:0];
    e_wv[c]++;
    e_addr[c] = f[11:8];
    e_data[c] = d;
    if (a >= 1 && a <= 8) e_dig[c][a-1] = d;
    else if (a == 9)  e_dec[c]  = d;
    else if (a == 10) e_int[c]  = d[3:0];
    else if (a == 11) e_scan[c] = d[2:0];
    else if (a == 12) e_shut[c] = d[0];
    else if (a == 15) e_test[c] = d[0];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One SPI bit; when live the bit enters the frame model and delay lines.
  task automatic shift_bit(input bit b, input bit live);
    bit b1;
    mosi = b;
    repeat (H) @(negedge clk_in);
    sclk = 1'b1;
    repeat (H) @(negedge clk_in);
    sclk = 1'b0;
    if (live) begin
      b1 = dq0.pop_front();
      dq0.push_back(b);
      dq1.pop_front();
      dq1.push_back(b1);
      acc[0] = {acc[0][30:0], b};
      acc[1] = {acc[1][30:0], b1};
      nbits++;
    end
  endtask

  task automatic frame_begin();
    @(negedge clk_in);
    cs = 1'b0;
    acc[0] = '0;
    acc[1] = '0;
    nbits = 0;
  endtask

  task automatic cs_release();
    repeat (H) @(negedge clk_in);
    cs = 1'b1;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic send(input logic [31:0] v, input int n);
    frame_begin();
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i], 1'b1);
    cs_release();
    for (int c = 0; c < 2; c++) begin
      if (nbits >= 16) model_load(c, acc[c][15:0]);
      else e_sf[c]++;
    end
  endtask

  task automatic rd(input int c, input int d, output logic [7:0] v);
    @(negedge clk_in);
    rdi[c] = 3'(d);
    #1;
    v = rdd[c];
  endtask

  task automatic check_all(input string ph);
    logic [7:0] v;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s_c%0d_wv_count", ph, c), n_wv[c], e_wv[c]);
      chk($sformatf("%s_c%0d_sf_count", ph, c), n_sf[c], e_sf[c]);
      chk($sformatf("%s_c%0d_wv_idle", ph, c), wv[c], 0);
      chk($sformatf("%s_c%0d_sf_idle", ph, c), sf[c], 0);
      chk($sformatf("%s_c%0d_reg_addr", ph, c), raddr[c], e_addr[c]);
      chk($sformatf("%s_c%0d_reg_data", ph, c), rdat[c], e_data[c]);
      chk($sformatf("%s_c%0d_decode", ph, c), dec[c], e_dec[c]);
      chk($sformatf("%s_c%0d_intensity", ph, c), inten[c], e_int[c]);
      chk($sformatf("%s_c%0d_scan", ph, c), scan[c], e_scan[c]);
      chk($sformatf("%s_c%0d_shutdown_n", ph, c), shut[c], e_shut[c]);
      chk($sformatf("%s_c%0d_disptest", ph, c), dtest[c], e_test[c]);
      for (int d = 0; d < 8; d++) begin
        rd(c, d, v);
        chk($sformatf("%s_c%0d_digit%0d", ph, c, d), v, e_dig[c][d]);
      end
    end
    chk({ph, "_c0_dout"}, dout[0], dq0[0]);
    chk({ph, "_c1_dout"}, dout[1], dq1[0]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  v;
    int          base_wv;
    int          base_sf;
    logic        d_before;
    logic [31:0] rv;
    int          n;

    rdi[0] = '0;
    rdi[1] = '0;
    model_reset();
    repeat (5) @(negedge clk_in);
    init = 1'b0;
    repeat (10) @(negedge clk_in);
    check_all("reset");

    // Intensity write
    base_wv = n_wv[0];
    send(32'h0A03, 16);
    chk("t1_wv_delta", n_wv[0] - base_wv, 1);
    chk("t1_addr", raddr[0], 4'hA);
    chk("t1_data", rdat[0], 8'h03);
    chk("t1_intensity", inten[0], 4'h3);
    check_all("t1");

    // Digit writes and shutdown
    send(32'h0155, 16);
    send(32'h08AA, 16);
    send(32'h0C01, 16);
    rd(0, 0, v); chk("t2_digit0", v, 8'h55);
    rd(0, 7, v); chk("t2_digit7", v, 8'hAA);
    chk("t2_shutdown_n", shut[0], 1'b1);
    check_all("t2");

    // Short frame
    base_wv = n_wv[0];
    base_sf = n_sf[0];
    send(32'hABC, 12);
    chk("t3_sf_delta", n_sf[0] - base_sf, 1);
    chk("t3_wv_delta", n_wv[0] - base_wv, 0);
    check_all("t3");

    // Daisy chain, one 32-bit frame
    send(32'h0C01_0108, 32);
    rd(0, 0, v); chk("t4_u0_digit0", v, 8'h08);
    chk("t4_u1_shutdown_n", shut[1], 1'b1);
    chk("t4_u1_addr", raddr[1], 4'hC);
    check_all("t4");

    // Reset in the middle of a frame
    base_wv = n_wv[0];
    base_sf = n_sf[0];
    rv = 32'h0F01;
    frame_begin();
    for (int i = 15; i >= 8; i--) shift_bit(rv[i], 1'b1);
    repeat (H) @(negedge clk_in);
    init = 1'b1;
    repeat (3) @(negedge clk_in);
    init = 1'b0;
    model_reset();
    for (int i = 7; i >= 0; i--) shift_bit(rv[i], 1'b0);
    cs_release();
    chk("t5_disptest_abort", dtest[0], 1'b0);
    chk("t5_wv_none", n_wv[0] - base_wv, 0);
    chk("t5_sf_none", n_sf[0] - base_sf, 0);
    check_all("t5a");
    send(32'h0F01, 16);
    chk("t5_disptest_set", dtest[0], 1'b1);
    check_all("t5b");

    // Unused addresses and no-op
    base_wv = n_wv[0];
    send(32'h0D77, 16);
    send(32'h0077, 16);
    chk("t6_wv_delta", n_wv[0] - base_wv, 2);
    check_all("t6");

    // SPI_CLK activity with CS high is ignored
    send(32'h0B05_0901, 32);
    d_before = dout[0];
    for (int i = 0; i < 6; i++) shift_bit(1'($urandom), 1'b0);
    repeat (8) @(negedge clk_in);
    chk("t7_dout_hold", dout[0], d_before);
    check_all("t7");

    // Random frames of mixed length
    for (int k = 0; k < 20; k++) begin
      rv = $urandom;
      case ($urandom_range(0, 5))
        0:       n = $urandom_range(1, 15);
        1, 2:    n = 16;
        3:       n = 24;
        default: n = 32;
      endcase
      send(rv, n);
      check_all($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
